lbdr_deroute: RTL
=================

LBDR_DEROUTE -- requirements
Module: lbdr_deroute

Interface
REQ-001 Parameter COORD_W, default 2, bits per X/Y coordinate; address is {y,x}, 2*COORD_W bits wide.
REQ-002 Parameter FID_W, default 3, flit_id width; HEADER=3'b001, BODY=3'b010, TAIL=3'b100.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cfg_we  in  1  load cfg_rxy, cfg_cx, cfg_cur, cfg_dr into the config registers.
REQ-006 cfg_rxy  in  8  routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne} (bit0=Rne).
REQ-007 cfg_cx  in  4  connectivity bits {Cs,Cw,Ce,Cn} (bit0=Cn).
REQ-008 cfg_cur  in  2*COORD_W  router address.
REQ-009 cfg_dr  in  2  deroute port code: 00=N, 01=E, 10=W, 11=S.
REQ-010 empty  in  1  input buffer empty; flit_id and dst_addr are ignored while high.
REQ-011 flit_id  in  FID_W  type of the flit at the buffer head.
REQ-012 dst_addr  in  2*COORD_W  destination address of the head flit.
REQ-013 port  out  5  registered one-hot grant {L,S,W,E,N} (bit0=N).
REQ-014 busy  out  1  high while a packet holds a route.
REQ-015 route_err  out  1  one-cycle pulse on an error event (see REQ-024, REQ-025, REQ-027).

Function
REQ-016 The comparator SHALL set N1=y_dst<y_cur, S1=y_cur<y_dst, E1=x_cur<x_dst and W1=x_dst<x_cur, all unsigned and COORD_W wide.
REQ-017 The minimal candidates SHALL be computed exactly as in classic LBDR: N=(N1&~E1&~W1 | N1&E1&Rne | N1&W1&Rnw)&Cn; E, W and S are formed analogously; L=~N1&~E1&~W1&~S1.
REQ-018 When more than one of N, E, W, S is a candidate, the grant SHALL be resolved by fixed priority N>E>W>S, so that port is always one-hot or zero.
REQ-019 The FSM SHALL have two states: IDLE and BUSY.
REQ-020 In IDLE, a HEADER with empty=0 SHALL update port on the next edge (1-cycle latency), set busy=1 and move the FSM to BUSY.
REQ-021 In BUSY, BODY flits and empty cycles SHALL hold port and the state unchanged.
REQ-022 In BUSY, a TAIL with empty=0 SHALL hold port for that cycle, then clear port and busy on the next edge and return the FSM to IDLE.
REQ-023 A HEADER+TAIL combination is not encoded; every packet SHALL have at least a HEADER and a TAIL.
REQ-024 A HEADER received in BUSY SHALL be re-routed as a new packet and SHALL pulse route_err.
REQ-025 A BODY or TAIL received in IDLE SHALL be ignored and SHALL pulse route_err.
REQ-026 Unreachable destination (L=0 and no minimal candidate): behaviour is defined by REQ-033 and REQ-034.
REQ-027 Any flit_id code other than HEADER, BODY or TAIL with empty=0 SHALL be ignored and SHALL pulse route_err.
REQ-028 When cfg_we and a HEADER occur in the same cycle, the HEADER SHALL be routed with the pre-write configuration; the new values take effect from the next cycle.
REQ-029 A config write SHALL never alter a route already held in BUSY.

Reset
REQ-030 On rst, the block SHALL set port=0, busy=0, route_err=0 and the FSM to IDLE.
REQ-031 On rst, the config registers SHALL be set to Rxy=8'd60, Cx=4'hF, cur=address with x=1 and y=1 (4'h5 for COORD_W=2), dr=2'b00.
REQ-032 rst asserted mid-packet SHALL abort the route; rst has priority over cfg_we and over all flits.

Configuration
REQ-033 With LBDR_DEROUTE_EN defined, an unreachable HEADER SHALL be granted the port coded by dr, provided that port's C bit is 1; the FSM then enters BUSY as normal. If that C bit is 0, port stays 0, route_err pulses and the FSM stays IDLE.
REQ-034 Without LBDR_DEROUTE_EN, an unreachable HEADER SHALL leave port=0, pulse route_err and keep the FSM in IDLE; cfg_dr is ignored.

Verification (COORD_W=2, cur=4'h5, defaults unless stated)
REQ-035 rst, then HEADER dst=4'h7, BODY, TAIL -> port=00010 one cycle after HEADER and held through TAIL; port=0 and busy=0 the cycle after TAIL.
REQ-036 HEADER dst=4'h5 -> port=10000 (L); HEADER dst=4'h0 with Rnw=1, Rwn=1 -> port=00001 (N wins priority).
REQ-037 Cx=4'b1110, HEADER dst=4'h1 -> unreachable; with LBDR_DEROUTE_EN and dr=01 -> port=00010; without the macro -> port=0 and route_err pulses.
REQ-038 BODY in IDLE -> route_err pulses and port stays 0; HEADER while BUSY -> route_err pulses and port takes the new route.
REQ-039 cfg_we with cx=0 coincident with HEADER dst=4'h7 -> port=00010; the next HEADER dst=4'h6 -> unreachable handling per REQ-033/REQ-034.
REQ-040 rst asserted in BUSY with empty=1 -> port=0, busy=0 on the next edge; Rxy reads back as 8'd60.

Source files
------------

// File: rtl/lbdr_deroute.sv
// LBDR route computation with a packet-hold FSM and optional deroute port.
// Optional feature: define LBDR_DEROUTE_EN to enable the deroute fallback.
module lbdr_deroute #(
    parameter int COORD_W = 2,
    parameter int FID_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [7:0]           cfg_rxy,
    input  logic [3:0]           cfg_cx,
    input  logic [2*COORD_W-1:0] cfg_cur,
    input  logic [1:0]           cfg_dr,
    input  logic                 empty,
    input  logic [FID_W-1:0]     flit_id,
    input  logic [2*COORD_W-1:0] dst_addr,
    output logic [4:0]           port,
    output logic                 busy,
    output logic                 route_err
);
    localparam int AW = 2 * COORD_W;
    localparam logic [FID_W-1:0] HEADER = FID_W'(3'b001);
    localparam logic [FID_W-1:0] BODY   = FID_W'(3'b010);
    localparam logic [FID_W-1:0] TAIL   = FID_W'(3'b100);
`ifdef LBDR_DEROUTE_EN
    localparam bit DR_EN = 1'b1;
`else
    localparam bit DR_EN = 1'b0;
`endif

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [4:0]    port_q, port_d;
    logic          err_q, err_d;
    logic [7:0]    rxy_q;
    logic [3:0]    cx_q;
    logic [AW-1:0] cur_q;
    logic [1:0]    dr_q;

    logic [COORD_W-1:0] xc, yc, xd, yd;
    logic n1, s1, e1, w1;
    logic rne, rnw, ren, res, rwn, rws, rse, rsw;
    logic cn, ce, cw, cs;
    logic cand_n, cand_e, cand_w, cand_s, cand_l;
    logic dr_ok, grant_ok;
    logic [4:0] grant;
    logic is_hdr, is_body, is_tail, is_bad;

    assign xc = cur_q[COORD_W-1:0];
    assign yc = cur_q[AW-1:COORD_W];
    assign xd = dst_addr[COORD_W-1:0];
    assign yd = dst_addr[AW-1:COORD_W];

    assign n1 = yd < yc;
    assign s1 = yc < yd;
    assign e1 = xc < xd;
    assign w1 = xd < xc;

    assign {rsw, rse, rws, rwn, res, ren, rnw, rne} = rxy_q;
    assign {cs, cw, ce, cn} = cx_q;

    assign cand_n = (n1 & ~e1 & ~w1 | n1 & e1 & rne | n1 & w1 & rnw) & cn;
    assign cand_e = (e1 & ~n1 & ~s1 | e1 & n1 & ren | e1 & s1 & res) & ce;
    assign cand_w = (w1 & ~n1 & ~s1 | w1 & n1 & rwn | w1 & s1 & rws) & cw;
    assign cand_s = (s1 & ~e1 & ~w1 | s1 & e1 & rse | s1 & w1 & rsw) & cs;
    assign cand_l = ~n1 & ~e1 & ~w1 & ~s1;

    // dr code doubles as both the C-bit index and the grant bit index
    assign dr_ok = DR_EN & cx_q[dr_q];

    always_comb begin
        grant    = '0;
        grant_ok = 1'b1;
        if (cand_l)      grant = 5'b10000;
        else if (cand_n) grant = 5'b00001;
        else if (cand_e) grant = 5'b00010;
        else if (cand_w) grant = 5'b00100;
        else if (cand_s) grant = 5'b01000;
        else if (dr_ok)  grant = 5'b00001 << dr_q;
        else             grant_ok = 1'b0;
    end

    assign is_hdr  = !empty && (flit_id == HEADER);
    assign is_body = !empty && (flit_id == BODY);
    assign is_tail = !empty && (flit_id == TAIL);
    assign is_bad  = !empty && !(is_hdr || is_body || is_tail);

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_hdr) begin
                    if (grant_ok) begin
                        port_d  = grant;
                        state_d = BUSY;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (is_body || is_tail || is_bad) begin
                    err_d = 1'b1;
                end
            end
            BUSY: begin
                if (is_hdr) begin
                    err_d = 1'b1;
                    if (grant_ok) begin
                        port_d = grant;
                    end else begin
                        port_d  = '0;
                        state_d = IDLE;
                    end
                end else if (is_tail) begin
                    port_d  = '0;
                    state_d = IDLE;
                end else if (is_bad) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                port_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            port_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxy_q <= 8'd60;
            cx_q  <= 4'hF;
            cur_q <= {COORD_W'(1), COORD_W'(1)};
            dr_q  <= 2'b00;
        end else if (cfg_we) begin
            rxy_q <= cfg_rxy;
            cx_q  <= cfg_cx;
            cur_q <= cfg_cur;
            dr_q  <= cfg_dr;
        end
    end

    assign port      = port_q;
    assign busy      = (state_q == BUSY);
    assign route_err = err_q;
endmodule
